btb_ctrl: RTL and testbench

Controller that owns the tag/valid/direction state for the branch target buffer and sequences every write into it. Sits between the EX/MEM branch-resolve path and the BTB target array. Provides fetch-stage hit/taken prediction from its own tag/valid/2-bit-counter state. Queues resolved branches, drains them one per cycle into counter updates and BTB target writes, and runs a full-array invalidation sweep after reset or on flush.

---
 rtl/btb_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_btb_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/btb_ctrl.sv
// Branch target buffer controller: owns tag/valid/2-bit direction state, queues
// resolved branches in a 2-entry FIFO and sequences BTB target writes and invalidation sweeps.
module btb_ctrl #(
  parameter int TAG = 27,
  parameter int PC  = 32
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          flush_in,
  input  logic [PC-1:0] fetch_pc_in,
  output logic          fetch_hit_out,
  output logic          fetch_taken_out,
  input  logic          resolve_valid_in,
  output logic          resolve_ready_out,
  input  logic [PC-1:0] resolve_pc_in,
  input  logic          resolve_taken_in,
  input  logic [PC-1:0] resolve_target_in,
  output logic          btb_update_out,
  output logic [PC-TAG-1:0] btb_index_out,
  output logic [PC-1:0] btb_new_pc_out,
  output logic          busy_out
);

  localparam int IDX  = PC - TAG;
  localparam int TW   = PC - IDX - 2;
  localparam int NENT = 2 ** IDX;
  localparam logic [IDX-1:0] PtrLast = {IDX{1'b1}};
  localparam logic [IDX-1:0] PtrOne  = {{(IDX-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_SWEEP = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [IDX-1:0]      ptr_q, ptr_d;
  logic [NENT-1:0]     valid_q, valid_d;
  logic [TW-1:0]       tag_q [NENT];
  logic [TW-1:0]       tag_d [NENT];
  logic [1:0]          ctr_q [NENT];
  logic [1:0]          ctr_d [NENT];

  logic [PC-1:0]       fifo_pc_q [2];
  logic [PC-1:0]       fifo_pc_d [2];
  logic [PC-1:0]       fifo_tg_q [2];
  logic [PC-1:0]       fifo_tg_d [2];
  logic [1:0]          fifo_tk_q, fifo_tk_d;
  logic                rd_q, rd_d;
  logic [1:0]          fcnt_q, fcnt_d;

  logic                upd_q, upd_d;
  logic [IDX-1:0]      idx_q, idx_d;
  logic [PC-1:0]       npc_q, npc_d;

  logic                push_s, pop_s, wr_s, head_hit_s;
  logic [PC-1:0]       head_pc_s;
  logic [IDX-1:0]      head_idx_s, fetch_idx_s;
  logic [TW-1:0]       head_tag_s, fetch_tag_s;

  assign resolve_ready_out = (fcnt_q != 2'd2);
  assign busy_out          = (state_q == ST_SWEEP);
  assign btb_update_out    = upd_q;
  assign btb_index_out     = idx_q;
  assign btb_new_pc_out    = npc_q;

  assign fetch_idx_s = fetch_pc_in[IDX+1:2];
  assign fetch_tag_s = fetch_pc_in[PC-1:IDX+2];
  assign head_pc_s   = fifo_pc_q[rd_q];
  assign head_idx_s  = head_pc_s[IDX+1:2];
  assign head_tag_s  = head_pc_s[PC-1:IDX+2];
  assign head_hit_s  = valid_q[head_idx_s] && (tag_q[head_idx_s] == head_tag_s);
  assign wr_s        = rd_q ^ fcnt_q[0];

  // Fetch lookup sees pre-update state and is blanked while the sweep runs.
  always_comb begin
    fetch_hit_out   = 1'b0;
    fetch_taken_out = 1'b0;
    if (state_q == ST_IDLE) begin
      fetch_hit_out   = valid_q[fetch_idx_s] && (tag_q[fetch_idx_s] == fetch_tag_s);
      fetch_taken_out = fetch_hit_out && ctr_q[fetch_idx_s][1];
    end else begin
      fetch_hit_out   = 1'b0;
      fetch_taken_out = 1'b0;
    end
  end

  // Next-state: sweep/drain FSM, entry state, FIFO and registered BTB write port.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    valid_d   = valid_q;
    tag_d     = tag_q;
    ctr_d     = ctr_q;
    fifo_pc_d = fifo_pc_q;
    fifo_tg_d = fifo_tg_q;
    fifo_tk_d = fifo_tk_q;
    rd_d      = rd_q;
    fcnt_d    = fcnt_q;
    upd_d     = 1'b0;
    idx_d     = idx_q;
    npc_d     = npc_q;
    push_s    = resolve_valid_in && resolve_ready_out && !flush_in;
    pop_s     = (state_q == ST_IDLE) && (fcnt_q != 2'd0) && !flush_in;

    if (flush_in) begin
      state_d = ST_SWEEP;
      ptr_d   = {IDX{1'b0}};
      fcnt_d  = 2'd0;
      rd_d    = 1'b0;
    end else begin
      case (state_q)
        ST_SWEEP: begin
          upd_d          = 1'b1;
          idx_d          = ptr_q;
          npc_d          = {PC{1'b0}};
          valid_d[ptr_q] = 1'b0;
          ctr_d[ptr_q]   = 2'b01;
          ptr_d          = ptr_q + PtrOne;
          if (ptr_q == PtrLast) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SWEEP;
          end
        end
        ST_IDLE: begin
          if (pop_s) begin
            if (head_hit_s) begin
              if (fifo_tk_q[rd_q]) begin
                if (ctr_q[head_idx_s] != 2'b11) begin
                  ctr_d[head_idx_s] = ctr_q[head_idx_s] + 2'b01;
                end else begin
                  ctr_d[head_idx_s] = 2'b11;
                end
                upd_d = 1'b1;
                idx_d = head_idx_s;
                npc_d = fifo_tg_q[rd_q];
              end else begin
                if (ctr_q[head_idx_s] != 2'b00) begin
                  ctr_d[head_idx_s] = ctr_q[head_idx_s] - 2'b01;
                end else begin
                  ctr_d[head_idx_s] = 2'b00;
                end
              end
            end else if (fifo_tk_q[rd_q]) begin
              valid_d[head_idx_s] = 1'b1;
              tag_d[head_idx_s]   = head_tag_s;
              ctr_d[head_idx_s]   = 2'b10;
              upd_d               = 1'b1;
              idx_d               = head_idx_s;
              npc_d               = fifo_tg_q[rd_q];
            end else begin
              upd_d = 1'b0;
            end
          end else begin
            upd_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_SWEEP;
          ptr_d   = {IDX{1'b0}};
        end
      endcase

      if (push_s) begin
        fifo_pc_d[wr_s] = resolve_pc_in;
        fifo_tg_d[wr_s] = resolve_target_in;
        fifo_tk_d[wr_s] = resolve_taken_in;
      end else begin
        fifo_tk_d = fifo_tk_q;
      end
      if (pop_s) begin
        rd_d = ~rd_q;
      end else begin
        rd_d = rd_q;
      end
      fcnt_d = fcnt_q + {1'b0, push_s} - {1'b0, pop_s};
    end
  end

  // State registers with synchronous reset into a fresh invalidation sweep.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= ST_SWEEP;
      ptr_q     <= {IDX{1'b0}};
      valid_q   <= {NENT{1'b0}};
      for (int i = 0; i < NENT; i++) begin
        tag_q[i] <= {TW{1'b0}};
        ctr_q[i] <= 2'b01;
      end
      for (int j = 0; j < 2; j++) begin
        fifo_pc_q[j] <= {PC{1'b0}};
        fifo_tg_q[j] <= {PC{1'b0}};
      end
      fifo_tk_q <= 2'b00;
      rd_q      <= 1'b0;
      fcnt_q    <= 2'd0;
      upd_q     <= 1'b0;
      idx_q     <= {IDX{1'b0}};
      npc_q     <= {PC{1'b0}};
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      ctr_q     <= ctr_d;
      fifo_pc_q <= fifo_pc_d;
      fifo_tg_q <= fifo_tg_d;
      fifo_tk_q <= fifo_tk_d;
      rd_q      <= rd_d;
      fcnt_q    <= fcnt_d;
      upd_q     <= upd_d;
      idx_q     <= idx_d;
      npc_q     <= npc_d;
    end
  end

endmodule

// File: tb/tb_btb_ctrl.sv
// Directed self-checking bench for btb_ctrl with hand-computed expectations.
module tb_btb_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in, flush_in;
  logic [31:0] fetch_pc_in;
  logic        fetch_hit_out, fetch_taken_out;
  logic        resolve_valid_in, resolve_ready_out, resolve_taken_in;
  logic [31:0] resolve_pc_in, resolve_target_in;
  logic        btb_update_out;
  logic [4:0]  btb_index_out;
  logic [31:0] btb_new_pc_out;
  logic        busy_out;

  int n_checks = 0;
  int n_fail   = 0;

  btb_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
    .fetch_pc_in(fetch_pc_in), .fetch_hit_out(fetch_hit_out),
    .fetch_taken_out(fetch_taken_out), .resolve_valid_in(resolve_valid_in),
    .resolve_ready_out(resolve_ready_out), .resolve_pc_in(resolve_pc_in),
    .resolve_taken_in(resolve_taken_in), .resolve_target_in(resolve_target_in),
    .btb_update_out(btb_update_out), .btb_index_out(btb_index_out),
    .btb_new_pc_out(btb_new_pc_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_wr(input string tag, input logic u, input logic [4:0] ix, input logic [31:0] d);
    chk({tag, ".upd"}, {31'd0, btb_update_out}, {31'd0, u});
    if (u) begin
      chk({tag, ".idx"}, {27'd0, btb_index_out}, {27'd0, ix});
      chk({tag, ".data"}, btb_new_pc_out, d);
    end
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic h, input logic t);
    fetch_pc_in = pc;
    #1;
    chk({tag, ".hit"}, {31'd0, fetch_hit_out}, {31'd0, h});
    chk({tag, ".taken"}, {31'd0, fetch_taken_out}, {31'd0, t});
  endtask

  // Offer one resolve for a single cycle, then let it pop on the following edge.
  task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    resolve_valid_in = 1'b1; resolve_pc_in = pc;
    resolve_taken_in = tk;   resolve_target_in = tgt;
    tick();
    resolve_valid_in = 1'b0;
    tick();
  endtask

  task automatic run_sweep(input string tag);
    for (int i = 0; i < 32; i++) begin
      tick();
      check_wr(tag, 1'b1, i[4:0], 32'd0);
      chk({tag, ".busy"}, {31'd0, busy_out}, {31'd0, (i != 31)});
    end
  endtask

  initial begin
    int waited;
    rst_in = 1'b1; flush_in = 1'b0; fetch_pc_in = 32'd0;
    resolve_valid_in = 1'b0; resolve_pc_in = 32'd0;
    resolve_taken_in = 1'b0; resolve_target_in = 32'd0;
    tick();
    rst_in = 1'b0;
    chk("rst.busy", {31'd0, busy_out}, 32'd1);
    chk("rst.upd", {31'd0, btb_update_out}, 32'd0);
    chk("rst.idx", {27'd0, btb_index_out}, 32'd0);
    chk("rst.data", btb_new_pc_out, 32'd0);
    chk("rst.ready", {31'd0, resolve_ready_out}, 32'd1);
    run_sweep("sweep0");
    tick();
    check_wr("idle0", 1'b0, 5'd0, 32'd0);
    lookup("post_sweep", 32'h0000_1008, 1'b0, 1'b0);

    // Allocate on taken miss
    resolve_valid_in = 1'b1; resolve_pc_in = 32'h0000_1008;
    resolve_taken_in = 1'b1; resolve_target_in = 32'h0000_2000;
    tick();
    resolve_valid_in = 1'b0;
    check_wr("alloc.pre", 1'b0, 5'd0, 32'd0);
    tick();
    check_wr("alloc", 1'b1, 5'd2, 32'h0000_2000);
    lookup("alloc.lk", 32'h0000_1008, 1'b1, 1'b1);
    lookup("alloc.tagdiff", 32'h0001_1008, 1'b0, 1'b0);

    // Counter 2 -> 1 -> 0 -> 0
    for (int k = 0; k < 3; k++) begin
      resolve(32'h0000_1008, 1'b0, 32'h0000_dead);
      check_wr("nt", 1'b0, 5'd0, 32'd0);
      lookup("nt.lk", 32'h0000_1008, 1'b1, 1'b0);
    end
    resolve(32'h0000_3004, 1'b0, 32'h0000_beef);
    check_wr("miss_nt", 1'b0, 5'd0, 32'd0);
    lookup("miss_nt.lk", 32'h0000_3004, 1'b0, 1'b0);

    // Three back-to-back pushes drain in order
    resolve_valid_in = 1'b1; resolve_taken_in = 1'b1;
    resolve_pc_in = 32'h0000_4010; resolve_target_in = 32'h0000_5000;
    chk("b2b.rdy0", {31'd0, resolve_ready_out}, 32'd1);
    tick();
    check_wr("b2b.w0", 1'b0, 5'd0, 32'd0);
    resolve_pc_in = 32'h0000_4014; resolve_target_in = 32'h0000_5100;
    chk("b2b.rdy1", {31'd0, resolve_ready_out}, 32'd1);
    tick();
    check_wr("b2b.w1", 1'b1, 5'd4, 32'h0000_5000);
    resolve_pc_in = 32'h0000_4018; resolve_target_in = 32'h0000_5200;
    chk("b2b.rdy2", {31'd0, resolve_ready_out}, 32'd1);
    tick();
    resolve_valid_in = 1'b0;
    check_wr("b2b.w2", 1'b1, 5'd5, 32'h0000_5100);
    tick();
    check_wr("b2b.w3", 1'b1, 5'd6, 32'h0000_5200);
    tick();
    check_wr("b2b.w4", 1'b0, 5'd0, 32'd0);

    // Pushes during a forced sweep; the third stalls
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    chk("fs.busy", {31'd0, busy_out}, 32'd1);
    check_wr("fs.nowr", 1'b0, 5'd0, 32'd0);
    resolve_valid_in = 1'b1; resolve_taken_in = 1'b1;
    resolve_pc_in = 32'h0000_1008; resolve_target_in = 32'h0000_2222;
    tick();
    chk("fs.rdy1", {31'd0, resolve_ready_out}, 32'd1);
    resolve_pc_in = 32'h0000_4010; resolve_taken_in = 1'b0;
    tick();
    chk("fs.rdy2", {31'd0, resolve_ready_out}, 32'd0);
    resolve_pc_in = 32'h0000_3004; resolve_taken_in = 1'b1;
    resolve_target_in = 32'h0000_3333;
    waited = 0;
    while (!resolve_ready_out && waited < 100) begin
      tick();
      waited++;
    end
    chk("fs.wait", waited, 32'd31);
    chk("fs.busy_end", {31'd0, busy_out}, 32'd0);
    check_wr("fs.popD", 1'b1, 5'd2, 32'h0000_2222);
    tick();
    resolve_valid_in = 1'b0;
    check_wr("fs.popE", 1'b0, 5'd0, 32'd0);
    tick();
    check_wr("fs.popF", 1'b1, 5'd1, 32'h0000_3333);
    lookup("fs.lkF", 32'h0000_3004, 1'b1, 1'b1);
    lookup("fs.lkE", 32'h0000_4010, 1'b0, 1'b0);

    // Flush in IDLE with two queued entries, then restart a sweep mid-way
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    resolve_valid_in = 1'b1; resolve_taken_in = 1'b1;
    resolve_pc_in = 32'h0000_6000; resolve_target_in = 32'h0000_7000;
    tick();
    resolve_pc_in = 32'h0000_6004; resolve_target_in = 32'h0000_7100;
    tick();
    resolve_valid_in = 1'b0;
    for (int k = 0; k < 30; k++) tick();
    chk("fi.busy", {31'd0, busy_out}, 32'd0);
    chk("fi.full", {31'd0, resolve_ready_out}, 32'd0);
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    check_wr("fi.cancel", 1'b0, 5'd0, 32'd0);
    chk("fi.busy2", {31'd0, busy_out}, 32'd1);
    chk("fi.empty", {31'd0, resolve_ready_out}, 32'd1);
    for (int k = 0; k < 10; k++) tick();
    check_wr("fr.at9", 1'b1, 5'd9, 32'd0);
    flush_in = 1'b1;
    resolve_valid_in = 1'b1; resolve_pc_in = 32'h0000_6008;
    resolve_taken_in = 1'b1; resolve_target_in = 32'h0000_7200;
    tick();
    flush_in = 1'b0; resolve_valid_in = 1'b0;
    check_wr("fr.cancel", 1'b0, 5'd0, 32'd0);
    run_sweep("sweep_restart");
    tick();
    check_wr("fr.dropped", 1'b0, 5'd0, 32'd0);
    lookup("fr.lk0", 32'h0000_6000, 1'b0, 1'b0);
    lookup("fr.lk2", 32'h0000_6008, 1'b0, 1'b0);

    // Reset and flush together with a pop pending
    resolve_valid_in = 1'b1; resolve_pc_in = 32'h0000_1008;
    resolve_taken_in = 1'b1; resolve_target_in = 32'h0000_9999;
    tick();
    resolve_valid_in = 1'b0;
    rst_in = 1'b1; flush_in = 1'b1;
    tick();
    rst_in = 1'b0; flush_in = 1'b0;
    chk("rf.busy", {31'd0, busy_out}, 32'd1);
    chk("rf.upd", {31'd0, btb_update_out}, 32'd0);
    chk("rf.idx", {27'd0, btb_index_out}, 32'd0);
    chk("rf.data", btb_new_pc_out, 32'd0);
    run_sweep("sweep_rf");
    tick();
    check_wr("rf.nopop", 1'b0, 5'd0, 32'd0);
    lookup("rf.lk", 32'h0000_1008, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
